// File: rtl/sensor_scheduler.sv
// Two-channel HC-SR04 scheduler: alternates trigger/echo measurements between
// the player-1 (ch0) and player-2 (ch1) paddle sensors and publishes one
// distance in centimetres per channel.
//
// Strobe semantics: dist_valid_o[c] and timeout_o[c] are single-cycle,
// registered pulses. They are mutually exclusive. dist_valid_o rises in the
// same cycle the matching distance register takes its new value.
module sensor_scheduler #(
    parameter int unsigned TRIG_CYCLES   = 650,
    parameter int unsigned CYCLES_PER_CM = 3770,
    parameter int unsigned MAX_CM        = 400,
    parameter int unsigned RISE_TIMEOUT  = 130000,
    parameter int unsigned GAP_CYCLES    = 3900000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [1:0] echo_i,
    output logic [1:0] trig_o,
    output logic [8:0] dist0_cm_o,
    output logic [8:0] dist1_cm_o,
    output logic [1:0] dist_valid_o,
    output logic [1:0] timeout_o,
    output logic       busy_o,
    output logic [2:0] state_o
);

    // One shared timer covers TRIG, WAIT_RISE and GAP, so size it for the longest.
    localparam int unsigned T_MAX_A = (TRIG_CYCLES > RISE_TIMEOUT) ? TRIG_CYCLES : RISE_TIMEOUT;
    localparam int unsigned T_MAX   = (T_MAX_A > GAP_CYCLES) ? T_MAX_A : GAP_CYCLES;
    localparam int TW = $clog2(T_MAX);
    localparam int PW = $clog2(CYCLES_PER_CM);

    localparam logic [TW-1:0] TRIG_LAST  = TW'(TRIG_CYCLES - 1);
    localparam logic [TW-1:0] RISE_LAST  = TW'(RISE_TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CYCLES_PER_CM - 1);
    localparam logic [8:0]    CM_SAT     = 9'(MAX_CM);
    localparam logic [8:0]    CM_PRE_SAT = 9'(MAX_CM - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_GAP       = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic          ch_q, ch_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [8:0]    cm_q, cm_d;
    logic [8:0]    dist0_q, dist0_d;
    logic [8:0]    dist1_q, dist1_d;
    logic [1:0]    valid_q, valid_d;
    logic [1:0]    timeout_q, timeout_d;
    logic [1:0]    echo_meta_q, echo_s_q;

    logic          echo_ch;
    logic          publish;
    logic [8:0]    pub_val;

    // Only the active channel's echo is ever looked at.
    assign echo_ch = echo_s_q[ch_q];

    // Two-flop synchronizer for the asynchronous echo pins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            echo_meta_q <= '0;
            echo_s_q    <= '0;
        end else begin
            echo_meta_q <= echo_i;
            echo_s_q    <= echo_meta_q;
        end
    end

    // State, counters, distance registers and strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            ch_q      <= 1'b0;
            timer_q   <= '0;
            presc_q   <= '0;
            cm_q      <= '0;
            dist0_q   <= '0;
            dist1_q   <= '0;
            valid_q   <= '0;
            timeout_q <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            timer_q   <= timer_d;
            presc_q   <= presc_d;
            cm_q      <= cm_d;
            dist0_q   <= dist0_d;
            dist1_q   <= dist1_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: trigger, wait for echo, measure, hold off, switch channel.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        timer_d   = timer_q + 1'b1;
        presc_d   = presc_q;
        cm_d      = cm_q;
        dist0_d   = dist0_q;
        dist1_d   = dist1_q;
        valid_d   = '0;
        timeout_d = '0;
        publish   = 1'b0;
        pub_val   = cm_q;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (enable_i) begin
                    state_d = S_TRIG;
                end
            end
            S_TRIG: begin
                if (timer_q == TRIG_LAST) begin
                    timer_d = '0;
                    state_d = S_WAIT_RISE;
                end
            end
            S_WAIT_RISE: begin
                if (echo_ch) begin
                    timer_d = '0;
                    presc_d = '0;
                    cm_d    = '0;
                    state_d = S_MEASURE;
                end else if (timer_q == RISE_LAST) begin
                    timer_d         = '0;
                    timeout_d[ch_q] = 1'b1;
                    state_d         = S_GAP;
                end
            end
            S_MEASURE: begin
                timer_d = '0;
                if (!echo_ch) begin
                    // Floor: any partial centimetre in the prescaler is dropped.
                    publish = 1'b1;
                    pub_val = cm_q;
                    state_d = S_GAP;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (cm_q == CM_PRE_SAT) begin
                        // Stuck-echo protection: saturate and move on without the fall.
                        cm_d    = CM_SAT;
                        publish = 1'b1;
                        pub_val = CM_SAT;
                        state_d = S_GAP;
                    end else begin
                        cm_d = cm_q + 9'd1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            S_GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    ch_d    = ~ch_q;
                    state_d = enable_i ? S_TRIG : S_IDLE;
                end
            end
            default: begin
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase

        if (publish) begin
            valid_d[ch_q] = 1'b1;
            if (ch_q) begin
                dist1_d = pub_val;
            end else begin
                dist0_d = pub_val;
            end
        end
    end

    // Trigger is decoded straight from registered state so reset drops it at once.
    assign trig_o       = (state_q == S_TRIG) ? (ch_q ? 2'b10 : 2'b01) : 2'b00;
    assign dist0_cm_o   = dist0_q;
    assign dist1_cm_o   = dist1_q;
    assign dist_valid_o = valid_q;
    assign timeout_o    = timeout_q;
    assign busy_o       = (state_q != S_IDLE);
    assign state_o      = state_q;

endmodule

// File: tb/tb_sensor_scheduler.sv
// Directed bench for sensor_scheduler with shortened timing parameters.
module tb_sensor_scheduler;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] echo = 2'b00;
    logic [1:0] trig;
    logic [8:0] dist0_cm;
    logic [8:0] dist1_cm;
    logic [1:0] dist_valid;
    logic [1:0] timeout;
    logic       busy;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int both_trig = 0;

    // Expected strobe events: {timeout[1:0], dist_valid[1:0], distance of that channel}.
    logic [12:0] exp_q[$];

    sensor_scheduler #(
        .TRIG_CYCLES  (4),
        .CYCLES_PER_CM(10),
        .MAX_CM       (20),
        .RISE_TIMEOUT (100),
        .GAP_CYCLES   (50)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .enable_i    (enable),
        .echo_i      (echo),
        .trig_o      (trig),
        .dist0_cm_o  (dist0_cm),
        .dist1_cm_o  (dist1_cm),
        .dist_valid_o(dist_valid),
        .timeout_o   (timeout),
        .busy_o      (busy),
        .state_o     (state)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_trig_rise(input logic [1:0] exp, input int budget, input string tag);
        int n;
        n = 0;
        while (trig == 2'b00 && n < budget) begin
            step();
            n++;
        end
        check_val(tag, trig, exp);
    endtask

    task automatic measure_trig_high(input int ch, output int n);
        n = 0;
        while (trig[ch] && n < 20) begin
            n++;
            step();
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check_val("scoreboard_drain", exp_q.size(), 0);
    endtask

    // Scoreboard: every strobe cycle must match the next expected event.
    always @(negedge clk) begin : monitor
        logic [12:0] ev;
        if (trig == 2'b11) both_trig++;
        if (dist_valid != 2'b00 || timeout != 2'b00) begin
            ev = {timeout, dist_valid, (dist_valid[1] | timeout[1]) ? dist1_cm : dist0_cm};
            if (exp_q.size() == 0) check_val("unexpected_strobe", ev, 0);
            else check_val("strobe_event", ev, exp_q.pop_front());
        end
    end

    initial begin
        int n;
        int t1_seen;
        logic [1:0] trig_acc;

        // Reset and first trigger on ch0.
        enable = 1'b1;
        repeat (3) step();
        check_val("reset_outputs", {trig, dist0_cm, dist1_cm, dist_valid, timeout, busy}, 0);
        check_val("reset_state", state, 0);
        rst_ni = 1'b1;
        step();
        check_val("trig_start", trig, 2'b01);
        check_val("busy_on", busy, 1);
        t1_seen = 0;
        n = 0;
        while (trig[0] && n < 20) begin
            if (trig[1]) t1_seen = 1;
            n++;
            step();
        end
        check_val("trig0_width", n, 4);
        check_val("trig1_quiet", t1_seen, 0);

        // Normal echo on ch0: 125 cycles -> 12 cm.
        exp_q.push_back({2'b00, 2'b01, 9'd12});
        repeat (20) step();
        echo[0] = 1'b1;
        repeat (125) step();
        echo[0] = 1'b0;
        wait_drain(100);
        check_val("dist0_normal", dist0_cm, 12);
        check_val("dist1_untouched", dist1_cm, 0);

        // Timeout on ch1.
        wait_trig_rise(2'b10, 200, "trig_ch1");
        measure_trig_high(1, n);
        check_val("trig1_width", n, 4);
        exp_q.push_back({2'b10, 2'b00, 9'd0});
        n = 0;
        while (timeout == 2'b00 && n < 200) begin
            step();
            n++;
        end
        check_val("timeout_latency", n, 100);
        check_val("dist1_after_timeout", dist1_cm, 0);
        n = 0;
        while (trig == 2'b00 && n < 200) begin
            step();
            n++;
        end
        check_val("gap_after_timeout", n, 50);
        check_val("trig_ch0_after_timeout", trig, 2'b01);

        // Saturation on ch0 with noise on inactive ch1.
        measure_trig_high(0, n);
        check_val("trig0_width_2", n, 4);
        exp_q.push_back({2'b00, 2'b01, 9'd20});
        repeat (5) step();
        echo[0] = 1'b1;
        n = 0;
        while (dist_valid == 2'b00 && n < 400) begin
            step();
            n++;
            if (n == 20 || n == 60) echo[1] = 1'b1;
            if (n == 40 || n == 80) echo[1] = 1'b0;
        end
        check_val("sat_latency", n, 203);
        check_val("dist0_sat", dist0_cm, 20);
        repeat (20) step();
        echo[0] = 1'b0;

        // Normal echo on ch1: 57 cycles -> 5 cm.
        wait_trig_rise(2'b10, 200, "trig_ch1_2");
        measure_trig_high(1, n);
        check_val("trig1_width_2", n, 4);
        repeat (10) step();
        exp_q.push_back({2'b00, 2'b10, 9'd5});
        echo[1] = 1'b1;
        repeat (57) step();
        echo[1] = 1'b0;
        wait_drain(100);
        check_val("dist1_normal", dist1_cm, 5);
        check_val("dist0_kept", dist0_cm, 20);

        // Reset in the middle of a ch0 trigger.
        wait_trig_rise(2'b01, 200, "trig_ch0_pre_reset");
        repeat (2) step();
        rst_ni = 1'b0;
        #1;
        check_val("async_trig_drop", {trig, busy}, 0);
        repeat (3) step();
        check_val("mid_reset_outputs", {trig, dist0_cm, dist1_cm, dist_valid, timeout, busy}, 0);
        rst_ni = 1'b1;
        wait_trig_rise(2'b01, 10, "restart_ch0");

        // Enable dropped during ch0 measurement: 80 cycles -> 7 cm, then idle.
        measure_trig_high(0, n);
        check_val("trig0_width_3", n, 4);
        repeat (3) step();
        exp_q.push_back({2'b00, 2'b01, 9'd7});
        echo[0] = 1'b1;
        repeat (10) step();
        enable = 1'b0;
        repeat (70) step();
        echo[0] = 1'b0;
        wait_drain(100);
        check_val("dist0_enable_drop", dist0_cm, 7);
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        check_val("idle_busy", busy, 0);
        check_val("idle_state", state, 0);
        trig_acc = 2'b00;
        repeat (100) begin
            step();
            trig_acc = trig_acc | trig;
        end
        check_val("no_trig_when_idle", trig_acc, 0);
        check_val("never_both_trig", both_trig, 0);
        check_val("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_scheduler.md
Name: sensor_scheduler

Overview:
- Time-multiplexed controller for the two HC-SR04 ultrasonic paddle sensors: channel 0 is player 1, channel 1 is player 2.
- Alternates measurements between the channels. For the active channel it issues the trigger pulse, times the echo pulse, converts the width to centimetres and publishes one distance per channel.
- Runs in the 65 MHz pixel-clock domain. Feeds the paddle-position logic.

Parameters:
- TRIG_CYCLES, 650: trigger high time in clk cycles (10 us).
- CYCLES_PER_CM, 3770: echo-high clk cycles per 1 cm (58 us).
- MAX_CM, 400: distance saturation value. Must be below 512.
- RISE_TIMEOUT, 130000: maximum cycles from trigger fall to echo rise (2 ms).
- GAP_CYCLES, 3900000: holdoff after each measurement before the next channel starts (60 ms).

Ports:
- clk  in  1  65 MHz system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  run the measurement loop.
- echo  in  2  raw echo inputs, one per channel. Asynchronous.
- trig  out  2  trigger outputs, one per channel.
- dist0_cm  out  9  last distance for channel 0.
- dist1_cm  out  9  last distance for channel 1.
- dist_valid  out  2  one-cycle strobe per channel when a new distance is written.
- timeout  out  2  one-cycle strobe per channel when no echo was received.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, async):
  - State = IDLE, channel pointer ch = 0.
  - trig = 0, dist0_cm = dist1_cm = 0, dist_valid = 0, timeout = 0, busy = 0.
  - All counters cleared.
  - Mid-measurement reset drops trig immediately and publishes nothing.
- Echo input:
  - Each echo bit passes through a 2-flop synchronizer. All decisions use the synchronized value echo_s.
  - Latency from a pin edge to echo_s is 2 clk.
- State machine (single shared timer, cm counter, prescaler):
  - IDLE: if enable=1, go to TRIG next cycle.
  - TRIG: trig[ch] = 1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE. The other trig bit stays 0 at all times.
  - WAIT_RISE:
    - echo_s[ch] = 1: clear prescaler and cm, go to MEASURE.
    - Timer reaches RISE_TIMEOUT: timeout[ch] = 1 for one cycle, distance register unchanged, go to GAP.
    - If echo_s[ch] is already high on entry, the echo is counted immediately.
  - MEASURE: each cycle with echo_s[ch] = 1 increments the prescaler. When it reaches CYCLES_PER_CM-1 it wraps to 0 and cm increments.
    - echo_s[ch] falls: dist{ch}_cm = cm (floor, partial cm discarded). dist_valid[ch] pulses the same cycle the register updates, one cycle after the fall is seen. Go to GAP.
    - cm reaches MAX_CM while echo is still high: publish MAX_CM with dist_valid, go to GAP without waiting for the fall (stuck-echo protection).
  - GAP:
    - Count GAP_CYCLES, then toggle ch.
    - If enable=1, go to TRIG; else go to IDLE.
    - The holdoff also applies after a timeout.
- enable is sampled only at the end of GAP and in IDLE. Deasserting it mid-measurement completes the current channel, including its GAP.
- Channel order is strictly 0,1,0,1… A timeout never causes a channel to be skipped or repeated.
- Echo on the inactive channel is ignored entirely.
- dist_valid and timeout are mutually exclusive and never both set in the same cycle.
- cm counter width is 9 bits and never exceeds MAX_CM.

Test Plan:
Bench overrides: TRIG_CYCLES=4, CYCLES_PER_CM=10, MAX_CM=20, RISE_TIMEOUT=100, GAP_CYCLES=50.
- Reset/trigger: release rst, enable=1 → trig[0] high exactly 4 cycles starting 1 cycle after IDLE exit. trig[1]=0 throughout. All outputs 0 during reset.
- Normal echo: echo[0] high for 125 cycles, 20 cycles after trig fall → dist0_cm=12, dist_valid=2'b01 for one cycle, dist1_cm stays 0. The next trigger is trig[1].
- Timeout: no echo on ch1 → timeout=2'b10 one cycle exactly 100 cycles after trig[1] fall. dist1_cm unchanged. Next trigger on ch0 after the 50-cycle gap.
- Saturation: echo[0] held high → dist0_cm=20 with dist_valid after 200 counted cycles, ignoring the later fall. Also, echo on inactive ch1 during ch0 MEASURE → no effect.
- Reset mid-operation: assert rst during TRIG → trig drops asynchronously, no strobes. After release, the sequence restarts on ch0.
- Enable drop: deassert enable during ch0 MEASURE → ch0 result published, GAP completes, then IDLE with busy=0 and no further trig.
